mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised, synchronously reset up/down counter with load, count enable, programmable modulus, and a wrap-or-saturate mode. It generalises the team's basic 8-bit counter for use as program counter, loop counter and address generator. It exposes a combinational carry for chaining several instances into wider counters, plus a sticky overflow flag for the control unit.

## Interface
Parameters:
- width, 8, counter and data width in bits (≥ 2)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- write  in  1  load `in` into counter
- enable  in  1  count when high; hold when low
- countdown  in  1  0 = count up, 1 = count down
- saturate  in  1  0 = wrap at terminal, 1 = clamp at terminal
- limit  in  width  top count value; range is 0..limit inclusive
- in  in  width  parallel load value
- out  out  width  current count (registered)
- carry  out  1  combinational: enable & ~write & ~saturate & at terminal (up: out ≥ limit; down: out == 0)
- overflow  out  1  sticky registered flag: a wrap or clamp event has occurred since the last reset or write

## Operation
- Priority per edge: reset > write > enable > hold.
- reset: out ← 0, overflow ← 0.
- write: out ← in, taken verbatim even if in > limit; overflow ← 0.
- enable, up, out < limit: out ← out + 1.
- enable, up, out ≥ limit:
  - wrap: out ← 0
  - saturate: out ← limit
  - either case: overflow ← 1
- enable, down, out > 0: out ← out − 1. This applies even if out > limit; the counter then walks down into range.
- enable, down, out == 0:
  - wrap: out ← limit
  - saturate: out stays 0
  - either case: overflow ← 1
- limit == 0: up or down is a terminal event every enabled cycle. out ← 0 and overflow ← 1.
- limit == 2^width−1: behaves as a plain binary counter; wrap goes to 0 with no arithmetic overflow beyond width.
- All arithmetic is width bits, unsigned. out never leaves 0..max(limit, last loaded value).
- limit, countdown and saturate are sampled every edge. A change takes effect on the next edge with no pipeline.
- Chaining: the low stage's carry drives the high stage's enable. Both stages share write and countdown, and both have saturate = 0.

## Timing
- Latency: one cycle from sampled control to new out. overflow updates on the same edge as the terminal event.
- carry is purely combinational from out, limit, countdown, enable, write and saturate. It has no registered delay and is valid before the edge on which the wrap happens.
- Reset values: out = 0, overflow = 0. carry evaluates to 0 after reset unless enable & ~write & ~saturate with limit == 0 or countdown.
- Reset asserted mid-count overrides write/enable on that edge. Counting resumes from 0 the edge after reset deasserts.
- write and enable together: the load wins, and no count is applied that cycle.
- Initial simulation value matches the reset value (0).

## Structure
- Shared defines file `counter_defs.vh`:
  - COUNT_UP / COUNT_DOWN constants
  - WRAP / SAT constants
  - default width
- One combinational sub-module `mod_counter_next`:
  - inputs: out, limit, countdown, saturate
  - outputs: next value and terminal flag
- The top level holds the out and overflow registers, the priority mux and the carry gating.

## Test plan
- Reset: run free with width=8, limit=255, then pulse reset → out=0, overflow=0 on the next edge regardless of write=1/enable=1 that cycle.
- Wrap up: limit=5, enable=1, up, wrap → out 0,1,2,3,4,5,0. carry=1 only while out=5. overflow rises at the 5→0 edge.
- Saturate down: load 2, then countdown, saturate → out 1,0,0,0. carry=0 throughout. overflow=1 from the first hold at 0.
- Load out-of-range: limit=10, write in=200, then count up with wrap → next out=0, overflow=1. Repeat with down → 199, 198, …
- Priority: write=1 and enable=1 with in=7 → out=7, overflow cleared. enable=0 → out holds for 3 cycles.
- Chain: two width=4 instances, limit=15, low carry → high enable. Count 0x00..0xFF → high increments exactly when low wraps. The combined value wraps 0xFF→0x00 at cycle 256.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// ----------------------------------------------------------------------------
// mod_counter_pkg
// Shared constants and types for the modulo up/down counter slice.
//   DEFAULT_WIDTH : default counter/data width in bits
//   count_dir_e   : counting direction (COUNT_UP / COUNT_DOWN)
//   end_mode_e    : behaviour at the terminal value (WRAP / SAT)
// ----------------------------------------------------------------------------
package mod_counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        COUNT_UP   = 1'b0,
        COUNT_DOWN = 1'b1
    } count_dir_e;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } end_mode_e;

endpackage

// File: rtl/mod_counter_if.sv
// ----------------------------------------------------------------------------
// mod_counter_if
// Bundles the control, data and status signals of one mod_counter.
//   write, enable, countdown, saturate : control inputs to the counter
//   limit                              : top count value (range 0..limit)
//   in                                 : parallel load value
//   out, carry, overflow               : counter status outputs
// Modports: master drives the controls, slave is the counter itself.
// ----------------------------------------------------------------------------
interface mod_counter_if
    import mod_counter_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
);

    logic             write;
    logic             enable;
    logic             countdown;
    logic             saturate;
    logic [width-1:0] limit;
    logic [width-1:0] in;
    logic [width-1:0] out;
    logic             carry;
    logic             overflow;

    modport master (
        output write, enable, countdown, saturate, limit, in,
        input  out, carry, overflow
    );

    modport slave (
        input  write, enable, countdown, saturate, limit, in,
        output out, carry, overflow
    );

endinterface

// File: rtl/mod_counter_next.sv
// ----------------------------------------------------------------------------
// mod_counter_next
// Purely combinational next-count calculation for mod_counter.
//   out       : current count
//   limit     : top count value
//   countdown : 0 = up, 1 = down
//   saturate  : 0 = wrap at terminal, 1 = clamp at terminal
//   next_val  : value the counter takes if it counts this cycle
//   terminal  : current count sits at the terminal for this direction
// ----------------------------------------------------------------------------
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic [width-1:0] out,
    input  logic [width-1:0] limit,
    input  logic             countdown,
    input  logic             saturate,
    output logic [width-1:0] next_val,
    output logic             terminal
);

    localparam logic [width-1:0] ONE  = {{(width-1){1'b0}}, 1'b1};
    localparam logic [width-1:0] ZERO = '0;

    count_dir_e dir;
    end_mode_e  mode;

    assign dir  = count_dir_e'(countdown);
    assign mode = end_mode_e'(saturate);

    // Up uses >= so a value loaded above limit is treated as terminal and
    // folds back into range; down only terminates at zero, so an
    // out-of-range load walks down into range instead.
    always_comb begin
        next_val = out;
        terminal = 1'b0;
        case (dir)
            COUNT_UP: begin
                terminal = (out >= limit);
                if (!terminal)
                    next_val = out + ONE;
                else if (mode == SAT)
                    next_val = limit;
                else
                    next_val = ZERO;
            end
            COUNT_DOWN: begin
                terminal = (out == ZERO);
                if (!terminal)
                    next_val = out - ONE;
                else if (mode == SAT)
                    next_val = ZERO;
                else
                    next_val = limit;
            end
            default: begin
                next_val = out;
                terminal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter
// Parametrised up/down counter with load, enable, programmable modulus and
// wrap-or-saturate behaviour; chains through a combinational carry.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset (out = 0, overflow = 0)
//   bus   : mod_counter_if slave (controls in, out/carry/overflow out)
// Edge priority: reset > write > enable > hold.
// ----------------------------------------------------------------------------
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    mod_counter_if.slave bus
);

    logic [width-1:0] out_d;
    logic [width-1:0] out_q;
    logic             overflow_d;
    logic             overflow_q;
    logic [width-1:0] next_val;
    logic             terminal;

    mod_counter_next #(
        .width(width)
    ) u_next (
        .out       (out_q),
        .limit     (bus.limit),
        .countdown (bus.countdown),
        .saturate  (bus.saturate),
        .next_val  (next_val),
        .terminal  (terminal)
    );

    // Load wins over counting; a load also clears the sticky overflow so the
    // control unit sees only events since its last write.
    always_comb begin
        out_d      = out_q;
        overflow_d = overflow_q;
        if (bus.write) begin
            out_d      = bus.in;
            overflow_d = 1'b0;
        end else if (bus.enable) begin
            out_d = next_val;
            if (terminal)
                overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    // Carry is only meaningful in wrap mode, where it feeds the enable of the
    // next stage in a chained counter.
    assign bus.carry    = bus.enable & ~bus.write & ~bus.saturate & terminal;
    assign bus.out      = out_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_mod_counter
// Scoreboard bench for mod_counter: an 8-bit instance for the directed
// vectors and two chained 4-bit instances for the cascade case.
// ----------------------------------------------------------------------------
module tb_mod_counter;

    logic clk;
    logic reset;

    mod_counter_if #(.width(8)) m_bus ();
    mod_counter_if #(.width(4)) lo_bus ();
    mod_counter_if #(.width(4)) hi_bus ();

    mod_counter #(.width(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m_bus)
    );

    mod_counter #(.width(4)) u_lo (
        .clk   (clk),
        .reset (reset),
        .bus   (lo_bus)
    );

    mod_counter #(.width(4)) u_hi (
        .clk   (clk),
        .reset (reset),
        .bus   (hi_bus)
    );

    // The low stage's carry is the high stage's count enable.
    assign hi_bus.enable = lo_bus.carry;

    typedef struct {
        int         kind;
        string      tag;
        logic [7:0] out;
        logic       ovf;
        logic       carry;
    } exp_t;

    exp_t scoreboard[$];
    int   checks   = 0;
    int   failures = 0;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive the 8-bit instance for one cycle. The expected values are what
    // must be visible during this cycle: out/overflow from the previous edge
    // and carry from the inputs applied now.
    task automatic applyStimulus(input string tag, input logic rst, input logic wr,
                                 input logic en, input logic cd, input logic sat,
                                 input logic [7:0] lim, input logic [7:0] din,
                                 input logic [7:0] eo, input logic eovf, input logic ec);
        exp_t e;
        reset           = rst;
        m_bus.write     = wr;
        m_bus.enable    = en;
        m_bus.countdown = cd;
        m_bus.saturate  = sat;
        m_bus.limit     = lim;
        m_bus.in        = din;
        e.kind  = 0;
        e.tag   = tag;
        e.out   = eo;
        e.ovf   = eovf;
        e.carry = ec;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Drive the chained pair for one cycle.
    task automatic applyChain(input logic en, input logic [7:0] ev,
                              input logic eovf, input logic ec);
        exp_t e;
        lo_bus.enable = en;
        e.kind  = 1;
        e.tag   = "chain";
        e.out   = ev;
        e.ovf   = eovf;
        e.carry = ec;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle, pop one expectation and compare it with the DUT.
    always @(negedge clk) begin
        if (scoreboard.size() != 0) begin
            exp_t e;
            e = scoreboard.pop_front();
            if (e.kind == 0) begin
                checkOutput({e.tag, ".out"}, m_bus.out, e.out);
                checkOutput({e.tag, ".overflow"}, {7'b0, m_bus.overflow}, {7'b0, e.ovf});
                checkOutput({e.tag, ".carry"}, {7'b0, m_bus.carry}, {7'b0, e.carry});
            end else begin
                checkOutput({e.tag, ".out"}, {hi_bus.out, lo_bus.out}, e.out);
                checkOutput({e.tag, ".overflow"}, {7'b0, lo_bus.overflow}, {7'b0, e.ovf});
                checkOutput({e.tag, ".carry"}, {7'b0, lo_bus.carry}, {7'b0, e.carry});
            end
        end
    end

    initial begin
        int drain;
        reset           = 1'b1;
        m_bus.write     = 1'b0;
        m_bus.enable    = 1'b0;
        m_bus.countdown = 1'b0;
        m_bus.saturate  = 1'b0;
        m_bus.limit     = 8'd255;
        m_bus.in        = 8'd0;
        lo_bus.write     = 1'b0;
        lo_bus.enable    = 1'b0;
        lo_bus.countdown = 1'b0;
        lo_bus.saturate  = 1'b0;
        lo_bus.limit     = 4'd15;
        lo_bus.in        = 4'd0;
        hi_bus.write     = 1'b0;
        hi_bus.countdown = 1'b0;
        hi_bus.saturate  = 1'b0;
        hi_bus.limit     = 4'd15;
        hi_bus.in        = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset behaviour while running free as a plain 8-bit counter.
        //            tag          rst wr en cd sat lim   din   out ovf c
        applyStimulus("rst_idle",  0, 0, 0, 0, 0, 8'd255, 8'd0,   8'd0,   0, 0);
        applyStimulus("free0",     0, 0, 1, 0, 0, 8'd255, 8'd0,   8'd0,   0, 0);
        applyStimulus("free1",     0, 0, 1, 0, 0, 8'd255, 8'd0,   8'd1,   0, 0);
        applyStimulus("load254",   0, 1, 1, 0, 0, 8'd255, 8'd254, 8'd2,   0, 0);
        applyStimulus("free254",   0, 0, 1, 0, 0, 8'd255, 8'd0,   8'd254, 0, 0);
        applyStimulus("free255",   0, 0, 1, 0, 0, 8'd255, 8'd0,   8'd255, 0, 1);
        applyStimulus("rst_pulse", 1, 1, 1, 0, 0, 8'd255, 8'd9,   8'd0,   1, 0);
        applyStimulus("after_rst", 0, 0, 0, 0, 0, 8'd255, 8'd0,   8'd0,   0, 0);

        // Wrap up with limit 5: 0..5 then 0, carry only at 5.
        applyStimulus("wrap_0",    0, 0, 1, 0, 0, 8'd5, 8'd0, 8'd0, 0, 0);
        applyStimulus("wrap_1",    0, 0, 1, 0, 0, 8'd5, 8'd0, 8'd1, 0, 0);
        applyStimulus("wrap_2",    0, 0, 1, 0, 0, 8'd5, 8'd0, 8'd2, 0, 0);
        applyStimulus("wrap_3",    0, 0, 1, 0, 0, 8'd5, 8'd0, 8'd3, 0, 0);
        applyStimulus("wrap_4",    0, 0, 1, 0, 0, 8'd5, 8'd0, 8'd4, 0, 0);
        applyStimulus("wrap_5",    0, 0, 1, 0, 0, 8'd5, 8'd0, 8'd5, 0, 1);
        applyStimulus("wrap_back", 0, 0, 1, 0, 0, 8'd5, 8'd0, 8'd0, 1, 0);
        applyStimulus("wrap_hold", 0, 0, 0, 0, 0, 8'd5, 8'd0, 8'd1, 1, 0);

        // Saturating count down from a load of 2.
        applyStimulus("sat_load",  0, 1, 0, 1, 1, 8'd5, 8'd2, 8'd1, 1, 0);
        applyStimulus("sat_dn2",   0, 0, 1, 1, 1, 8'd5, 8'd0, 8'd2, 0, 0);
        applyStimulus("sat_dn1",   0, 0, 1, 1, 1, 8'd5, 8'd0, 8'd1, 0, 0);
        applyStimulus("sat_dn0",   0, 0, 1, 1, 1, 8'd5, 8'd0, 8'd0, 0, 0);
        applyStimulus("sat_hold0", 0, 0, 1, 1, 1, 8'd5, 8'd0, 8'd0, 1, 0);
        applyStimulus("sat_hold1", 0, 0, 1, 1, 1, 8'd5, 8'd0, 8'd0, 1, 0);

        // Out-of-range load above limit 10, counting up then down.
        applyStimulus("oor_load",  0, 1, 0, 0, 0, 8'd10, 8'd200, 8'd0,   1, 0);
        applyStimulus("oor_up",    0, 0, 1, 0, 0, 8'd10, 8'd0,   8'd200, 0, 1);
        applyStimulus("oor_upres", 0, 0, 0, 0, 0, 8'd10, 8'd0,   8'd0,   1, 0);
        applyStimulus("oor_load2", 0, 1, 0, 1, 0, 8'd10, 8'd200, 8'd0,   1, 0);
        applyStimulus("oor_dn200", 0, 0, 1, 1, 0, 8'd10, 8'd0,   8'd200, 0, 0);
        applyStimulus("oor_dn199", 0, 0, 1, 1, 0, 8'd10, 8'd0,   8'd199, 0, 0);
        applyStimulus("oor_dn198", 0, 0, 1, 1, 0, 8'd10, 8'd0,   8'd198, 0, 0);
        applyStimulus("oor_dnres", 0, 0, 0, 1, 0, 8'd10, 8'd0,   8'd197, 0, 0);

        // limit 0 is terminal every enabled cycle, then write beats enable.
        applyStimulus("lim0_a",    0, 0, 1, 0, 0, 8'd0,  8'd0, 8'd197, 0, 1);
        applyStimulus("lim0_b",    0, 0, 1, 0, 0, 8'd0,  8'd0, 8'd0,   1, 1);
        applyStimulus("prio_wr",   0, 1, 1, 0, 0, 8'd10, 8'd7, 8'd0,   1, 0);
        applyStimulus("hold_a",    0, 0, 0, 0, 0, 8'd10, 8'd0, 8'd7,   0, 0);
        applyStimulus("hold_b",    0, 0, 0, 0, 0, 8'd10, 8'd0, 8'd7,   0, 0);
        applyStimulus("hold_c",    0, 0, 0, 0, 0, 8'd10, 8'd0, 8'd7,   0, 0);

        // limit 0 counting down from 0 wraps onto limit with carry.
        applyStimulus("dn0_load",  0, 1, 0, 1, 0, 8'd0,  8'd0, 8'd7,   0, 0);
        applyStimulus("dn0_wrap",  0, 0, 1, 1, 0, 8'd0,  8'd0, 8'd0,   0, 1);
        applyStimulus("dn0_res",   0, 0, 0, 1, 0, 8'd0,  8'd0, 8'd0,   1, 0);

        // Saturating count up clamps at limit, carry stays low.
        applyStimulus("satup_ld",  0, 1, 0, 0, 1, 8'd5,  8'd4, 8'd0,   1, 0);
        applyStimulus("satup_4",   0, 0, 1, 0, 1, 8'd5,  8'd0, 8'd4,   0, 0);
        applyStimulus("satup_5",   0, 0, 1, 0, 1, 8'd5,  8'd0, 8'd5,   0, 0);
        applyStimulus("satup_5b",  0, 0, 1, 0, 1, 8'd5,  8'd0, 8'd5,   1, 0);
        applyStimulus("satup_res", 0, 0, 0, 0, 1, 8'd5,  8'd0, 8'd5,   1, 0);

        // Chained pair: combined value counts 0x00..0xFF and wraps to 0x00.
        for (int i = 0; i <= 256; i++) begin
            logic [7:0] v;
            v = i[7:0];
            applyChain(1'b1, v, (i >= 16), (v[3:0] == 4'hF));
        end
        lo_bus.enable = 1'b0;

        drain = 0;
        while (scoreboard.size() != 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (scoreboard.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", scoreboard.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
